uart_rx: RTL

UART receiver that deserialises the asynchronous serial input into parallel data words, using the 16x oversampling tick produced by `uart_baudgen` (`o_baud_x16`). It sits between the `uart_baudgen` and the host-side FIFO/register interface. It detects the start bit, samples each bit at mid-period and checks optional parity and the stop bit. Each frame is delivered as a one-cycle valid strobe with error flags.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, optional parity, one stop bit.
// Delivers each frame as a one-cycle o_valid strobe with parity/framing flags.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_baud_x16,
    input  logic                 i_rx,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [3:0]             tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   perr_q;

    logic tick_clr;
    logic ld_cfg;
    logic shift_en;
    logic par_smp;
    logic stop_smp;
    logic mid_tick;
    logic end_tick;

    // Synchroniser resets to the idle-line level so reset never fakes a start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign mid_tick = (tick_cnt == 4'd7);
    assign end_tick = (tick_cnt == 4'd15);
    assign o_busy   = (state_q != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_clr = 1'b0;
        ld_cfg   = 1'b0;
        shift_en = 1'b0;
        par_smp  = 1'b0;
        stop_smp = 1'b0;
        if (i_baud_x16) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d  = START;
                        tick_clr = 1'b1;
                    end
                end
                START: begin
                    if (mid_tick) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = DATA;
                            tick_clr = 1'b1;
                            ld_cfg   = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (end_tick) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (end_tick) begin
                        par_smp = 1'b1;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (end_tick) begin
                        stop_smp = 1'b1;
                        state_d  = rx_s ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            perr_q       <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_baud_x16) begin
                tick_cnt <= tick_clr ? 4'd0 : tick_cnt + 4'd1;
            end
            // Parity config is frozen here so mid-frame changes are ignored.
            if (ld_cfg) begin
                bit_cnt   <= '0;
                par_en_q  <= i_parity_en;
                par_odd_q <= i_parity_odd;
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_smp) begin
                perr_q <= ((^shift_q) ^ rx_s) != par_odd_q;
            end
            if (stop_smp) begin
                o_data       <= shift_q;
                o_parity_err <= par_en_q & perr_q;
                o_frame_err  <= ~rx_s;
                o_valid      <= 1'b1;
            end
        end
    end

endmodule
